// File: rtl/dac_spi_multi_out.sv
// ============================================================================
// dac_spi_multi_out
//
// Multi-channel SPI transmitter for serial DACs. A single i_Send handshake
// latches one word per channel. Each channel is then sent as its own
// chip-select frame, MSB first, with channel 0 first. Between frames,
// chip-select is held high for a fixed number of system clocks.
//
// Optional feature (macro DAC_SPI_LDAC_EN):
//   When the macro is defined, an o_LDAC_n strobe is added. It pulses low
//   for 2*CLOCK_COUNT clocks after the last channel's gap, so that all DAC
//   outputs update together. When the macro is undefined, the port and the
//   LDAC state do not exist.
//
// Parameters:
//   DATA_WIDTH    bits per SPI frame (>= 2)
//   CHANNELS      frames sent per accepted i_Send (>= 1)
//   CLOCK_COUNT   system clocks per SPI clock half-period (>= 1)
//   CS_HIGH_COUNT system clocks o_SPI_CS stays high after each frame (>= 1)
//   CPOL          idle level of o_SPI_Clock
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset_n    asynchronous active-low reset
//   i_Data       channel n in bits [n*DATA_WIDTH +: DATA_WIDTH]
//   i_Send       transfer request, accepted only while o_Ready=1
//   o_Ready      1 = idle, able to accept i_Send
//   o_SPI_CS     active-low chip select
//   o_SPI_Clock  SPI clock
//   o_SPI_Data   SPI data, MSB first
//   o_Channel    index of the channel being sent, 0 when idle
//   o_LDAC_n     (DAC_SPI_LDAC_EN only) active-low load-DAC strobe
// ============================================================================
module dac_spi_multi_out #(
    parameter int DATA_WIDTH    = 24,
    parameter int CHANNELS      = 2,
    parameter int CLOCK_COUNT   = 10,
    parameter int CS_HIGH_COUNT = 2,
    parameter bit CPOL          = 1'b1
) (
    input  logic                                               i_Clock,
    input  logic                                               i_Reset_n,
    input  logic [CHANNELS*DATA_WIDTH-1:0]                     i_Data,
    input  logic                                               i_Send,
    output logic                                               o_Ready,
    output logic                                               o_SPI_CS,
    output logic                                               o_SPI_Clock,
    output logic                                               o_SPI_Data,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] o_Channel
`ifdef DAC_SPI_LDAC_EN
    ,
    output logic                                               o_LDAC_n
`endif
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int DIV_W = $clog2(2 * CLOCK_COUNT);
    localparam int GAP_W = (CS_HIGH_COUNT > 1) ? $clog2(CS_HIGH_COUNT) : 1;

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLOCK_COUNT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLOCK_COUNT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HIGH_COUNT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
`ifdef DAC_SPI_LDAC_EN
        ,
        ST_LDAC
`endif
    } state_t;

    state_t                         state;
    logic [BIT_W-1:0]               bit_cnt;
    logic [DIV_W-1:0]               div_cnt;
    logic [GAP_W-1:0]               gap_cnt;
    // Word of the current frame; bit DATA_WIDTH-1 is always the bit on the wire.
    logic [DATA_WIDTH-1:0]          shift_reg;
    // Channels not yet sent. The next channel is always in the low word.
    logic [CHANNELS*DATA_WIDTH-1:0] pending;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state       <= ST_IDLE;
            o_Ready     <= 1'b1;
            o_SPI_CS    <= 1'b1;
            o_SPI_Clock <= CPOL;
            o_SPI_Data  <= 1'b0;
            o_Channel   <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            gap_cnt     <= '0;
            // NOTE: the data registers are cleared as well, so nothing left
            // over from an aborted transfer can appear on the pins.
            shift_reg   <= '0;
            pending     <= '0;
`ifdef DAC_SPI_LDAC_EN
            o_LDAC_n    <= 1'b1;
`endif
        end else begin
            // NOTE: every state register uses non-blocking assignment. This
            // lets each branch read the values from before this edge.
            case (state)
                ST_IDLE: begin
                    if (i_Send) begin
                        shift_reg   <= i_Data[DATA_WIDTH-1:0];
                        pending     <= i_Data >> DATA_WIDTH;
                        o_SPI_Data  <= i_Data[DATA_WIDTH-1];
                        o_Ready     <= 1'b0;
                        o_SPI_CS    <= 1'b0;
                        o_SPI_Clock <= CPOL;
                        o_Channel   <= '0;
                        bit_cnt     <= '0;
                        div_cnt     <= '0;
                        state       <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        // Bit boundary. Returning SCLK to idle is the DAC's
                        // sampling edge for the bit that just ended.
                        div_cnt     <= '0;
                        o_SPI_Clock <= CPOL;
                        if (bit_cnt == BIT_LAST) begin
                            o_SPI_CS   <= 1'b1;
                            o_SPI_Data <= 1'b0;
                            bit_cnt    <= '0;
                            gap_cnt    <= '0;
                            state      <= ST_GAP;
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            shift_reg  <= shift_reg << 1;
                            o_SPI_Data <= shift_reg[DATA_WIDTH-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        if (div_cnt == DIV_HALF) begin
                            o_SPI_Clock <= ~CPOL;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (o_Channel == CH_LAST) begin
                            o_Channel <= '0;
`ifdef DAC_SPI_LDAC_EN
                            o_LDAC_n  <= 1'b0;
                            div_cnt   <= '0;
                            state     <= ST_LDAC;
`else
                            o_Ready   <= 1'b1;
                            state     <= ST_IDLE;
`endif
                        end else begin
                            o_Channel  <= o_Channel + 1'b1;
                            shift_reg  <= pending[DATA_WIDTH-1:0];
                            pending    <= pending >> DATA_WIDTH;
                            o_SPI_Data <= pending[DATA_WIDTH-1];
                            o_SPI_CS   <= 1'b0;
                            bit_cnt    <= '0;
                            div_cnt    <= '0;
                            state      <= ST_SHIFT;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

`ifdef DAC_SPI_LDAC_EN
                ST_LDAC: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        o_LDAC_n <= 1'b1;
                        o_Ready  <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_multi_out.sv
module tb_dac_spi_multi_out;

    // DUT A: 24-bit, 2 channels, CLOCK_COUNT=2, CS_HIGH_COUNT=3, CPOL=1.
    // DUT B: 16-bit, 1 channel, CLOCK_COUNT=1, CS_HIGH_COUNT=2, CPOL=0.
`ifdef DAC_SPI_LDAC_EN
    localparam int LDAC_CLKS = 4;
`else
    localparam int LDAC_CLKS = 0;
`endif
    localparam int RDY_A = 198 + LDAC_CLKS;  // 2*(24*2*2+3)
    localparam int LEN_A = 96;               // 24*2*2
    localparam int GAP_A = 3;
    localparam int RDY_B = 34;               // 16*2*1+2
    localparam int LEN_B = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [47:0] a_data = '0;
    logic        a_send = 1'b0;
    logic        a_ready, a_cs, a_sclk, a_sdo;
    logic        a_chan;
    logic [15:0] b_data = '0;
    logic        b_send = 1'b0;
    logic        b_ready, b_cs, b_sclk, b_sdo;
    logic        b_chan;
`ifdef DAC_SPI_LDAC_EN
    logic        a_ldac;
`endif

    always #5 clk = ~clk;

    dac_spi_multi_out #(
        .DATA_WIDTH(24), .CHANNELS(2), .CLOCK_COUNT(2), .CS_HIGH_COUNT(3), .CPOL(1'b1)
    ) dut_a (
        .i_Clock    (clk),
        .i_Reset_n  (rst_n),
        .i_Data     (a_data),
        .i_Send     (a_send),
        .o_Ready    (a_ready),
        .o_SPI_CS   (a_cs),
        .o_SPI_Clock(a_sclk),
        .o_SPI_Data (a_sdo),
        .o_Channel  (a_chan)
`ifdef DAC_SPI_LDAC_EN
        ,
        .o_LDAC_n   (a_ldac)
`endif
    );

    dac_spi_multi_out #(
        .DATA_WIDTH(16), .CHANNELS(1), .CLOCK_COUNT(1), .CS_HIGH_COUNT(2), .CPOL(1'b0)
    ) dut_b (
        .i_Clock    (clk),
        .i_Reset_n  (rst_n),
        .i_Data     (b_data),
        .i_Send     (b_send),
        .o_Ready    (b_ready),
        .o_SPI_CS   (b_cs),
        .o_SPI_Clock(b_sclk),
        .o_SPI_Data (b_sdo),
        .o_Channel  (b_chan)
`ifdef DAC_SPI_LDAC_EN
        ,
        .o_LDAC_n   ()
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- pin monitors (sampled on the falling clock edge) ------
    logic [23:0] q_word[$];
    int          q_bits[$], q_len[$], q_gap[$], q_rdy[$], q_chan[$], q_ldac[$];
    int          ma_viol = 0, ma_lviol = 0;
    logic [15:0] qb_word[$];
    int          qb_bits[$], qb_len[$], qb_rdy[$];
    int          mb_viol = 0;

    initial begin : mon_a
        logic pcs, psclk, pdata, pready, pldac;
        logic [23:0] word;
        int bits, low, high, rdy, lcnt;
        pcs = 1'b1; psclk = 1'b1; pdata = 1'b0; pready = 1'b1; pldac = 1'b1;
        word = '0; bits = 0; low = 0; high = 0; rdy = 0; lcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pcs = 1'b1; psclk = 1'b1; pdata = 1'b0; pready = 1'b1; pldac = 1'b1;
                word = '0; bits = 0; low = 0; high = 0; rdy = 0; lcnt = 0;
            end else begin
                // CPOL=1: the DAC samples on SCLK rising back to idle.
                if (!pcs && !psclk && a_sclk) begin
                    word = {word[22:0], pdata};
                    bits++;
                end
                if (pcs && a_cs && (a_sclk !== psclk || a_sclk !== 1'b1)) ma_viol++;
                if (a_ready && a_chan !== 1'b0) ma_viol++;
                if (!pcs && a_cs) begin
                    q_word.push_back(word); q_bits.push_back(bits); q_len.push_back(low);
                    word = '0; bits = 0; low = 0; high = 0;
                end
                if (pcs && !a_cs) begin
                    if (!pready) q_gap.push_back(high);
                    q_chan.push_back(int'(a_chan));
                    high = 0;
                end
                if (a_cs) high++; else low++;
                if (!a_ready) rdy++;
                if (!pready && a_ready) begin q_rdy.push_back(rdy); rdy = 0; end
`ifdef DAC_SPI_LDAC_EN
                if (!a_ldac) begin lcnt++; if (!a_cs) ma_lviol++; end
                if (!pldac && a_ldac) begin q_ldac.push_back(lcnt); lcnt = 0; end
                pldac = a_ldac;
`endif
                pcs = a_cs; psclk = a_sclk; pdata = a_sdo; pready = a_ready;
            end
        end
    end

    initial begin : mon_b
        logic pcs, psclk, pdata, pready;
        logic [15:0] word;
        int bits, low, rdy;
        pcs = 1'b1; psclk = 1'b0; pdata = 1'b0; pready = 1'b1;
        word = '0; bits = 0; low = 0; rdy = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pcs = 1'b1; psclk = 1'b0; pdata = 1'b0; pready = 1'b1;
                word = '0; bits = 0; low = 0; rdy = 0;
            end else begin
                // CPOL=0: the DAC samples on SCLK falling back to idle.
                if (!pcs && psclk && !b_sclk) begin
                    word = {word[14:0], pdata};
                    bits++;
                end
                if (pcs && b_cs && (b_sclk !== psclk || b_sclk !== 1'b0)) mb_viol++;
                if (!pcs && b_cs) begin
                    qb_word.push_back(word); qb_bits.push_back(bits); qb_len.push_back(low);
                    word = '0; bits = 0; low = 0;
                end
                if (!b_cs) low++;
                if (!b_ready) rdy++;
                if (!pready && b_ready) begin qb_rdy.push_back(rdy); rdy = 0; end
                pcs = b_cs; psclk = b_sclk; pdata = b_sdo; pready = b_ready;
            end
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic clear_queues();
        q_word.delete(); q_bits.delete(); q_len.delete(); q_gap.delete();
        q_rdy.delete(); q_chan.delete(); q_ldac.delete();
        qb_word.delete(); qb_bits.delete(); qb_len.delete(); qb_rdy.delete();
    endtask

    task automatic wait_idle(input bit use_b, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (((use_b ? b_ready : a_ready) !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: o_Ready still 0 after %0d clocks, required 1", tag, n);
        end
    endtask

    typedef struct {
        logic [23:0] ch0;
        logic [23:0] ch1;
        bit          busy;   // pulse i_Send during the transfer
        logic [23:0] exp0;   // word the DAC must sample in frame 0
        logic [23:0] exp1;   // word the DAC must sample in frame 1
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [15:0] exp;
    } bvec_t;

    task automatic check_frames_a(input string tag, input logic [23:0] w0, input logic [23:0] w1);
        check({tag, "_frames"}, q_word.size(), 2);
        check({tag, "_w0"}, q_word[0], w0);
        check({tag, "_w1"}, q_word[1], w1);
        check({tag, "_bits0"}, q_bits[0], 24);
        check({tag, "_len0"}, q_len[0], LEN_A);
        check({tag, "_len1"}, q_len[1], LEN_A);
        check({tag, "_gap"}, q_gap[0], GAP_A);
        check({tag, "_rdy"}, q_rdy[0], RDY_A);
        check({tag, "_chan0"}, q_chan[0], 0);
        check({tag, "_chan1"}, q_chan[1], 1);
`ifdef DAC_SPI_LDAC_EN
        check({tag, "_ldac_len"}, q_ldac[0], LDAC_CLKS);
`endif
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clear_queues();
        @(posedge clk); #1;
        a_data = {v.ch1, v.ch0};
        a_send = 1'b1;
        @(posedge clk); #1;          // accepted on this edge
        a_send = 1'b0;
        a_data = ~a_data;            // must not reach the pins
        if (v.busy) begin
            repeat (96) @(posedge clk);
            #1 a_send = 1'b1;        // seen during the CS-high gap
            @(posedge clk); #1 a_send = 1'b0;
            repeat (30) @(posedge clk);
            #1 a_send = 1'b1;        // seen during channel 1
            @(posedge clk); #1 a_send = 1'b0;
        end
        wait_idle(1'b0, tag);
        repeat (20) @(negedge clk);  // also proves no extra transfer started
        check_frames_a(tag, v.exp0, v.exp1);
    endtask

    vec_t  vecs[4];
    bvec_t bvecs[2];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vecs[0] = '{ch0: 24'hA5F00F, ch1: 24'h123456, busy: 1'b0, exp0: 24'hA5F00F, exp1: 24'h123456};
        vecs[1] = '{ch0: 24'hFFFFFF, ch1: 24'h000000, busy: 1'b0, exp0: 24'hFFFFFF, exp1: 24'h000000};
        vecs[2] = '{ch0: 24'h800001, ch1: 24'h7FFFFE, busy: 1'b1, exp0: 24'h800001, exp1: 24'h7FFFFE};
        vecs[3] = '{ch0: 24'h000001, ch1: 24'h800000, busy: 1'b1, exp0: 24'h000001, exp1: 24'h800000};
        bvecs[0] = '{data: 16'h8001, exp: 16'h8001};
        bvecs[1] = '{data: 16'h7FFE, exp: 16'h7FFE};

        // Reset state
        #23;
        check("rst_ready", a_ready, 1);
        check("rst_cs", a_cs, 1);
        check("rst_sclk", a_sclk, 1);
        check("rst_data", a_sdo, 0);
        check("rst_chan", a_chan, 0);
        check("rst_b_sclk", b_sclk, 0);
`ifdef DAC_SPI_LDAC_EN
        check("rst_ldac", a_ldac, 1);
`endif
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Table-driven transfers on DUT A
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // i_Send held high: back-to-back, each transfer uses its own data
        clear_queues();
        @(posedge clk); #1;
        a_data = {24'h111111, 24'hC3C3C3};
        a_send = 1'b1;
        @(posedge clk);
        repeat (50) @(posedge clk);
        #1 a_data = {24'h0F0F0F, 24'h5A5A5A};
        wait_idle(1'b0, "b2b_first");
        @(negedge clk);
        check("b2b_accept", a_ready, 0);
        a_data = {24'hDEAD00, 24'h00BEEF};
        repeat (20) @(posedge clk);
        #1 a_send = 1'b0;
        wait_idle(1'b0, "b2b_second");
        repeat (20) @(negedge clk);
        check("b2b_frames", q_word.size(), 4);
        check("b2b_w0", q_word[0], 24'hC3C3C3);
        check("b2b_w1", q_word[1], 24'h111111);
        check("b2b_w2", q_word[2], 24'h5A5A5A);
        check("b2b_w3", q_word[3], 24'h0F0F0F);
        check("b2b_rdy0", q_rdy[0], RDY_A);
        check("b2b_rdy1", q_rdy[1], RDY_A);
        check("b2b_gap0", q_gap[0], GAP_A);
        check("b2b_gap1", q_gap[1], GAP_A);

        // Reset in the middle of bit 10 of channel 0
        clear_queues();
        @(posedge clk); #1;
        a_data = {24'h00BEEF, 24'hC0FFEE};
        a_send = 1'b1;
        @(posedge clk); #1 a_send = 1'b0;
        repeat (41) @(posedge clk);
        #1 check("mid_cs_low", a_cs, 0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_cs", a_cs, 1);
        check("abort_sclk", a_sclk, 1);
        check("abort_data", a_sdo, 0);
        check("abort_ready", a_ready, 1);
        check("abort_chan", a_chan, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_frame", q_word.size(), 0);
        check("abort_no_rdy", q_rdy.size(), 0);
        run_vec(vecs[0], "after_rst");

        // DUT B: CPOL=0, 16-bit, single channel
        for (int i = 0; i < 2; i++) begin
            clear_queues();
            @(posedge clk); #1;
            b_data = bvecs[i].data;
            b_send = 1'b1;
            @(posedge clk); #1 b_send = 1'b0;
            b_data = ~b_data;
            wait_idle(1'b1, $sformatf("b%0d", i));
            repeat (10) @(negedge clk);
            check($sformatf("b%0d_frames", i), qb_word.size(), 1);
            check($sformatf("b%0d_word", i), qb_word[0], bvecs[i].exp);
            check($sformatf("b%0d_bits", i), qb_bits[0], 16);
            check($sformatf("b%0d_len", i), qb_len[0], LEN_B);
            check($sformatf("b%0d_rdy", i), qb_rdy[0], RDY_B);
            check($sformatf("b%0d_chan", i), b_chan, 0);
        end

        // Protocol invariants collected over the whole run
        check("a_sclk_idle_or_chan", ma_viol, 0);
        check("b_sclk_idle", mb_viol, 0);
`ifdef DAC_SPI_LDAC_EN
        check("ldac_during_cs", ma_lviol, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
